regbank_seq: RTL and testbench

- Hardware initiator for the 32x32 two-read/one-write register bank.
- Performs the fill and dump sequences that previously existed only in simulation.
- FILL writes an arithmetic sequence into a contiguous, wrapping register range.
- DUMP reads a range two registers per cycle and streams the pairs out over a valid/ready interface.
- Sits between a control agent and the register bank. It drives the bank's address, data and write ports directly.

---
 rtl/regbank_seq.sv | 145 ++++++++++++++
 tb/tb_regbank_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_seq.sv
// Hardware fill/dump initiator for the 32x32 two-read/one-write register bank.
// FILL writes an arithmetic sequence; DUMP streams register pairs over valid/ready.
module regbank_seq #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base_addr,
  input  logic [5:0]    count,
  input  logic [DW-1:0] fill_val,
  input  logic [DW-1:0] fill_step,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rb_sr1,
  output logic [AW-1:0] rb_sr2,
  output logic [AW-1:0] rb_dr,
  output logic [DW-1:0] rb_wrdata,
  output logic          rb_write,
  input  logic [DW-1:0] rb_rdData1,
  input  logic [DW-1:0] rb_rdData2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr1,
  output logic [DW-1:0] out_data1,
  output logic [AW-1:0] out_addr2,
  output logic [DW-1:0] out_data2,
  output logic          out_v2,
  output logic          out_last
);

  // state | meaning
  // IDLE  | waiting for start; command inputs captured on start
  // FILL  | one bank write per cycle, count cycles
  // DUMP  | reading pairs into the output register, waiting on out_ready
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DUMP, S_FIN} state_t;

  localparam logic [5:0] CMAX = 6'(2 ** AW);

  state_t        state, state_nx;
  logic [AW-1:0] base_q;
  logic [5:0]    cnt_q;
  logic [5:0]    idx_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] step_q;
  logic [5:0]    cnt_in;
  logic [5:0]    npairs;
  logic          accept;
  logic          out_fire;
  logic          load;

  assign cnt_in   = (count > CMAX) ? CMAX : count;
  assign npairs   = 6'((7'(cnt_q) + 7'd1) >> 1);
  assign accept   = (state == S_IDLE) && start;
  assign out_fire = out_valid && out_ready;
  assign load     = (state == S_DUMP) && (idx_q < npairs) && (!out_valid || out_ready);

  // Index doubles as write offset in FILL and pair number in DUMP.
  assign rb_dr     = base_q + AW'(idx_q);
  assign rb_wrdata = acc_q;
  assign rb_sr1    = base_q + AW'({idx_q, 1'b0});
  assign rb_sr2    = rb_sr1 + AW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rb_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cnt_in == 6'd0) state_nx = S_FIN;
          else if (mode)      state_nx = S_DUMP;
          else                state_nx = S_FILL;
        end
      end
      S_FILL: begin
        busy     = 1'b1;
        rb_write = 1'b1;
        if (idx_q == cnt_q - 6'd1) state_nx = S_FIN;
      end
      S_DUMP: begin
        busy = 1'b1;
        if (out_fire && out_last) state_nx = S_FIN;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      out_valid <= 1'b0;
      out_addr1 <= '0;
      out_data1 <= '0;
      out_addr2 <= '0;
      out_data2 <= '0;
      out_v2    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        cnt_q  <= cnt_in;
        acc_q  <= fill_val;
        step_q <= fill_step;
        idx_q  <= '0;
      end else if (state == S_FILL) begin
        acc_q <= acc_q + step_q;
        idx_q <= idx_q + 6'd1;
      end else if (load) begin
        idx_q <= idx_q + 6'd1;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_addr1 <= rb_sr1;
        out_addr2 <= rb_sr2;
        out_data1 <= rb_rdData1;
        out_data2 <= rb_rdData2;
        out_v2    <= ({idx_q, 1'b1} < {1'b0, cnt_q});
        out_last  <= (idx_q == npairs - 6'd1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regbank_seq.sv
// Directed bench for regbank_seq with a behavioural 32x32 register bank.
module tb_regbank_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  count = '0;
  logic [31:0] fill_val = '0;
  logic [31:0] fill_step = '0;
  logic        out_ready = 1'b0;
  logic        busy, done, rb_write, out_valid, out_v2, out_last;
  logic [4:0]  rb_sr1, rb_sr2, rb_dr, out_addr1, out_addr2;
  logic [31:0] rb_wrdata, rb_rdData1, rb_rdData2, out_data1, out_data2;

  logic [31:0] bank    [32];
  logic [31:0] exp_reg [32];
  int n_chk = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_vld = 0;

  always #5 clk = ~clk;

  regbank_seq #(.AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .count(count), .fill_val(fill_val), .fill_step(fill_step),
    .busy(busy), .done(done),
    .rb_sr1(rb_sr1), .rb_sr2(rb_sr2), .rb_dr(rb_dr), .rb_wrdata(rb_wrdata), .rb_write(rb_write),
    .rb_rdData1(rb_rdData1), .rb_rdData2(rb_rdData2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr1(out_addr1), .out_data1(out_data1), .out_addr2(out_addr2), .out_data2(out_data2),
    .out_v2(out_v2), .out_last(out_last)
  );

  assign rb_rdData1 = bank[rb_sr1];
  assign rb_rdData2 = bank[rb_sr2];

  always @(posedge clk) begin
    if (rb_write) begin
      bank[rb_dr] <= rb_wrdata;
      n_wr <= n_wr + 1;
    end
    if (out_valid) n_vld <= n_vld + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 32; k++)
      chk($sformatf("%s_reg%0d", tag, k), bank[k], exp_reg[k]);
  endtask

  task automatic run_fill(input logic [4:0] b, input logic [5:0] c,
                          input logic [31:0] v, input logic [31:0] s);
    int eff, cyc, w0;
    bit seen;
    eff = (c > 6'd32) ? 32 : int'(c);
    @(negedge clk);
    mode = 1'b0; base_addr = b; count = c; fill_val = v; fill_step = s; start = 1'b1;
    w0 = n_wr;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("fill_busy", 32'(busy), (eff > 0) ? 32'd1 : 32'd0);
    seen = 1'b0;
    while (cyc <= 40) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    chk("fill_done_seen", 32'(seen), 32'd1);
    chk("fill_done_cyc", 32'(cyc), 32'(eff + 1));
    chk("fill_writes", 32'(n_wr - w0), 32'(eff));
    for (int k = 0; k < eff; k++) exp_reg[5'(b + k)] = v + 32'(k) * s;
    @(negedge clk);
    chk("fill_done_pulse", 32'(done), 32'd0);
    check_regs("fill");
  endtask

  task automatic run_dump(input logic [4:0] b, input logic [5:0] c, input bit tog);
    int eff, np, got, cyc, first, v0;
    bit seen, stall, v2e;
    logic [31:0] h_a1, h_d1, h_a2, h_d2;
    logic [4:0] a;
    bit rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    eff = (c > 6'd32) ? 32 : int'(c);
    np = (eff + 1) / 2;
    got = 0; first = -1; seen = 1'b0; stall = 1'b0;
    h_a1 = '0; h_d1 = '0; h_a2 = '0; h_d2 = '0;
    @(negedge clk);
    mode = 1'b1; base_addr = b; count = c; start = 1'b1; out_ready = 1'b0;
    v0 = n_vld;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      if (done) begin seen = 1'b1; break; end
      if (stall) begin
        chk("hold_a1", 32'(out_addr1), h_a1);
        chk("hold_d1", out_data1, h_d1);
        chk("hold_a2", 32'(out_addr2), h_a2);
        chk("hold_d2", out_data2, h_d2);
      end
      if (out_valid && first < 0) first = cyc;
      out_ready = tog ? rp[cyc % 4] : 1'b1;
      if (out_valid && out_ready) begin
        a = 5'(int'(b) + 2 * got);
        v2e = (2 * got + 1 < eff);
        chk("pair_a1", 32'(out_addr1), 32'(a));
        chk("pair_d1", out_data1, exp_reg[a]);
        chk("pair_a2", 32'(out_addr2), 32'(5'(a + 5'd1)));
        if (v2e) chk("pair_d2", out_data2, exp_reg[5'(a + 5'd1)]);
        chk("pair_v2", 32'(out_v2), 32'(v2e));
        chk("pair_last", 32'(out_last), (got == np - 1) ? 32'd1 : 32'd0);
        got++;
      end
      stall = out_valid && !out_ready;
      h_a1 = 32'(out_addr1); h_d1 = out_data1; h_a2 = 32'(out_addr2); h_d2 = out_data2;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("dump_done_seen", 32'(seen), 32'd1);
    chk("dump_pairs", 32'(got), 32'(np));
    if (np > 0) chk("dump_latency", 32'(first), 32'd1);
    if (!tog) chk("dump_done_cyc", 32'(cyc), (np == 0) ? 32'd0 : 32'(np + 1));
    if (np == 0) chk("dump_no_valid", 32'(n_vld - v0), 32'd0);
    @(negedge clk);
    chk("dump_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int nd;
    for (int k = 0; k < 32; k++) exp_reg[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_write", 32'(rb_write), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_v2", 32'(out_v2), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_dr", 32'(rb_dr), 32'd0);
    chk("rst_wrdata", rb_wrdata, 32'd0);
    chk("rst_sr1", 32'(rb_sr1), 32'd0);
    chk("rst_addr1", 32'(out_addr1), 32'd0);
    chk("rst_data1", out_data1, 32'd0);
    reset = 1'b1;

    run_fill(5'd0, 6'd32, 32'd0, 32'd10);
    run_dump(5'd0, 6'd32, 1'b0);
    run_dump(5'd0, 6'd32, 1'b1);
    run_dump(5'd3, 6'd11, 1'b1);

    run_fill(5'd30, 6'd4, 32'hFFFF_FFFE, 32'd1);
    run_dump(5'd28, 6'd8, 1'b0);
    run_dump(5'd5, 6'd3, 1'b0);

    run_fill(5'd7, 6'd0, 32'h1234, 32'd5);
    run_dump(5'd7, 6'd0, 1'b0);
    run_fill(5'd0, 6'd40, 32'd7, 32'd3);
    run_dump(5'd0, 6'd40, 1'b0);

    // Abort a FILL during its 10th write.
    @(negedge clk);
    mode = 1'b0; base_addr = 5'd0; count = 6'd32; fill_val = 32'd1000; fill_step = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_write", 32'(rb_write), 32'd1);
    chk("abort_pre_dr", 32'(rb_dr), 32'd9);
    reset = 1'b0;
    #1;
    chk("abort_write_drop", 32'(rb_write), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dr", 32'(rb_dr), 32'd0);
    nd = 0;
    repeat (2) begin @(negedge clk); nd += int'(done); end
    reset = 1'b1;
    repeat (5) begin @(negedge clk); nd += int'(done); end
    chk("abort_no_done", 32'(nd), 32'd0);
    for (int k = 0; k < 9; k++) exp_reg[k] = 32'd1000 + 32'(k);
    check_regs("abort");
    run_dump(5'd0, 6'd19, 1'b0);
    run_fill(5'd12, 6'd3, 32'hA5A5_0000, 32'h0101);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
